// File: rtl/byte_bit_sequencer_if.sv
// Purpose : word-in / bit-out handshake bundle for byte_bit_sequencer.
// Latency : none (pure signal grouping).
// Backpressure: carries in_valid/in_ready and bit_valid/bit_ready pairs.
//
// Ports/signals:
//   in_data[WIDTH], in_valid, in_ready   - word input handshake
//   bit_out, bit_valid, bit_ready        - serial bit output handshake
//   bit_last                             - final beat of the current word
//   busy                                 - a word is in flight
// Modports:
//   master - word producer / bit consumer (drives in_*, bit_ready)
//   slave  - the sequencer itself
interface byte_bit_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_last;
  logic             busy;

  modport master (
    output in_data, in_valid, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last, busy
  );

  modport slave (
    input  in_data, in_valid, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last, busy
  );
endinterface

// File: rtl/byte_bit_sequencer.sv
// Purpose : accepts one WIDTH-bit word and replays it LSB first as a bit stream.
// Latency : first bit is valid one cycle after the word handshake.
// Backpressure: bits hold while bit_ready=0; in_ready stays low until the word
//               (and any trailing gap) has completed -- words are never queued.
//
// Ports:
//   clk    - single clock, all state on posedge
//   reset  - synchronous, active-high; aborts any word in flight
//   bus    - byte_bit_sequencer_if.slave (in_data/in_valid/in_ready,
//            bit_out/bit_valid/bit_ready/bit_last, busy)
// Parameters:
//   WIDTH      bits per word, 2..32
//   GAP_CYCLES idle cycles after the final beat before in_ready returns, 0..255
// Build option:
//   BYTE_SEQ_PARITY_EN - appends one even-parity beat to every word; bit_last
//                        moves onto that beat. Undefined: WIDTH beats per word.
module byte_bit_sequencer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic                 clk,
  input logic                 reset,
  byte_bit_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  // Where a word goes once its final beat has been taken.
  localparam logic [1:0] S_AFTER  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  // GAP lasts GAP_CYCLES cycles: the counter runs 0..GAP_CYCLES-1.
  localparam logic [7:0]    GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;

`ifdef BYTE_SEQ_PARITY_EN
  // Parity is taken from the word at the handshake, since shreg is consumed
  // as the bits go out.
  logic             parity_q,  parity_d;
  localparam logic  PARITY_ON = 1'b1;
`else
  localparam logic  PARITY_ON = 1'b0;
`endif

  logic accept;
  logic bit_take;
  logic on_last_bit;

  assign accept      = (state_q == S_IDLE) && bus.in_valid && !reset;
  assign bit_take    = bus.bit_ready && (state_q == S_SHIFT || state_q == S_PARITY);
  assign on_last_bit = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef BYTE_SEQ_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d   = bus.in_data;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
`ifdef BYTE_SEQ_PARITY_EN
          parity_d  = ^bus.in_data;
`endif
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bus.bit_ready) begin
          shreg_d = shreg_q >> 1;
          if (on_last_bit) begin
            // Counter parks on WIDTH-1 rather than wrapping past it.
`ifdef BYTE_SEQ_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_AFTER;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      S_PARITY: begin
`ifdef BYTE_SEQ_PARITY_EN
        if (bus.bit_ready) begin
          state_d = S_AFTER;
        end
`else
        // Unreachable without the parity build; recover to IDLE.
        state_d = S_IDLE;
`endif
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // State registers, synchronous reset
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
`ifdef BYTE_SEQ_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
`ifdef BYTE_SEQ_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // ------------------------------------------------------------------
  // Outputs: all decoded from registered state, except in_ready which is
  // also forced low while reset is held.
  // ------------------------------------------------------------------
  logic bit_out_w;
  logic bit_last_w;

  always_comb begin
    bit_out_w  = 1'b0;
    bit_last_w = 1'b0;
    if (state_q == S_SHIFT) begin
      bit_out_w  = shreg_q[0];
      bit_last_w = on_last_bit && !PARITY_ON;
    end
`ifdef BYTE_SEQ_PARITY_EN
    else if (state_q == S_PARITY) begin
      bit_out_w  = parity_q;
      bit_last_w = 1'b1;
    end
`endif
  end

  assign bus.in_ready  = (state_q == S_IDLE) && !reset;
  assign bus.bit_valid = (state_q == S_SHIFT) || (state_q == S_PARITY);
  assign bus.bit_out   = bit_out_w;
  assign bus.bit_last  = bit_last_w;
  assign bus.busy      = (state_q != S_IDLE);

  // bit_take is only informative for readers; keep it tied into a term so
  // it documents that bit_ready outside SHIFT/PARITY has no effect.
  logic unused_ok;
  assign unused_ok = bit_take;

endmodule

// File: tb/tb_byte_bit_sequencer.sv
// Bench for byte_bit_sequencer: two instances (GAP_CYCLES 0 and 3) driven in
// lockstep, compared every cycle against a word/beat-level reference model.
module tb_byte_bit_sequencer;

  localparam int WIDTH = 8;
`ifdef BYTE_SEQ_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             bit_ready;

  byte_bit_sequencer_if #(.WIDTH(WIDTH)) if0 ();
  byte_bit_sequencer_if #(.WIDTH(WIDTH)) if1 ();

  assign if0.in_data   = in_data;
  assign if0.in_valid  = in_valid;
  assign if0.bit_ready = bit_ready;
  assign if1.in_data   = in_data;
  assign if1.in_valid  = in_valid;
  assign if1.bit_ready = bit_ready;

  byte_bit_sequencer #(.WIDTH(WIDTH), .GAP_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  byte_bit_sequencer #(.WIDTH(WIDTH), .GAP_CYCLES(3)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a word is either being emitted (beat index idx of
  // BEATS), sitting in its trailing gap, or absent.
  int         gcfg [2] = '{0, 3};
  bit         act  [2];
  logic [7:0] word [2];
  int         idx  [2];
  int         gap  [2];

  task automatic check_dut(input int i, input logic rdy, input logic vld,
                           input logic o, input logic lst, input logic bsy);
    logic [3:0] exp_f;
    logic [3:0] obs_f;
    logic       exp_o;
    exp_f = {(!act[i] && gap[i] == 0 && !reset), act[i],
             (act[i] && idx[i] == BEATS - 1), (act[i] || gap[i] > 0)};
    obs_f = {rdy, vld, lst, bsy};
    vectors++;
    assert (obs_f === exp_f) else begin
      miscompares++;
      $error("FAIL flags dut%0d t=%0t observed(rdy,vld,last,busy)=%b expected=%b", i, $time, obs_f, exp_f);
    end
    if (act[i]) begin
      exp_o = (idx[i] < WIDTH) ? word[i][idx[i]] : ^word[i];
      vectors++;
      assert (o === exp_o) else begin
        miscompares++;
        $error("FAIL bit_out dut%0d t=%0t beat=%0d observed=%b expected=%b", i, $time, idx[i], o, exp_o);
      end
    end
  endtask

  // One clock: check outputs at negedge, advance model at posedge.
  task automatic step();
    @(negedge clk);
    check_dut(0, if0.in_ready, if0.bit_valid, if0.bit_out, if0.bit_last, if0.busy);
    check_dut(1, if1.in_ready, if1.bit_valid, if1.bit_out, if1.bit_last, if1.busy);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        act[i] = 0; gap[i] = 0; idx[i] = 0;
      end else if (act[i]) begin
        if (bit_ready) begin
          idx[i]++;
          if (idx[i] == BEATS) begin
            act[i] = 0;
            gap[i] = gcfg[i];
          end
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end else if (in_valid) begin
        act[i] = 1; word[i] = in_data; idx[i] = 0;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; word[i] = '0; idx[i] = 0; gap[i] = 0;
    end
    reset = 1'b1; in_valid = 1'b0; in_data = '0; bit_ready = 1'b0;
    run(2);

    // Reset state: bit_out low on both instances.
    vectors++;
    assert ({if0.bit_out, if1.bit_out} === 2'b00) else begin
      miscompares++;
      $error("FAIL reset_bit_out observed=%b%b expected=00", if0.bit_out, if1.bit_out);
    end
    reset = 1'b0;
    run(1);

    // 0xA5 with continuous bit_ready; data changes right after the handshake.
    in_data = 8'hA5; in_valid = 1'b1; bit_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = 8'h5A;
    run(14);

    // 0x3C with bit_ready toggling.
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      bit_ready = k[0] ? 1'b0 : 1'b1;
      step();
    end
    bit_ready = 1'b1;
    run(4);

    // 0xFF then 0x00 with in_valid held: gap spacing between accepts.
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    run(8);
    in_data = 8'h00;
    run(6);
    in_valid = 1'b0;
    run(12);

    // Reset during the 4th bit of 0x81, then 0x01 from bit 0.
    in_data = 8'h81; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    in_data = 8'h01; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run(12);

    // Parity-relevant words 0x07 and 0x03 back to back.
    in_data = 8'h07; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run(13);
    in_data = 8'h03; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run(13);

    // 0x55 pulsed on in_valid while a word (0xC3) is in flight.
    in_data = 8'hC3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run(2);
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    run(14);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = WIDTH'($urandom);
      bit_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 80) == 0);
      step();
    end
    reset = 1'b0; in_valid = 1'b0; bit_ready = 1'b1;
    run(16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
